// File: rtl/sha256_hex_tx.sv
// sha256_hex_tx
//   Turns a finished digest into ASCII hex text and feeds it to a byte-wide
//   UART transmitter, one character per handshake. The first character is the
//   digest's most significant nibble. A CR LF terminator can optionally follow.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   start    one-cycle request; digest is sampled here, only while idle
//   digest   hash value; bit [DIGEST_BITS-1] is the MS bit of the first char
//   tx_busy  busy from the UART transmitter
//   tx_send  registered one-cycle send strobe to the transmitter
//   tx_data  registered character; stable while tx_send is high
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse once the last character has left the line
module sha256_hex_tx #(
    parameter int DIGEST_BITS = 256,
    parameter int UPPERCASE   = 0,
    parameter int APPEND_CRLF = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   tx_busy,
    output logic                   tx_send,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   done
);

    localparam int NCHARS = DIGEST_BITS / 4;
    localparam int NTOT   = NCHARS + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam int KW     = (NTOT > 1) ? $clog2(NTOT) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(NTOT - 1);
    localparam logic [31:0]   NCHARS_U = NCHARS;
    localparam logic [7:0]    HEX_A    = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_HOLD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [KW-1:0]          k_reg, k_next;
    logic [DIGEST_BITS-1:0] shreg_reg, shreg_next;
    logic                   tx_send_reg, tx_send_next;
    logic [7:0]             tx_data_reg, tx_data_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    logic [3:0]             nibble;
    logic                   k_is_hex;
    logic [7:0]             char_k;

    assign tx_send = tx_send_reg;
    assign tx_data = tx_data_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

    // Character for the current index. Once the hex part is exhausted the
    // remaining indices (only present with the terminator) are CR then LF,
    // and LF is always the last one.
    assign nibble   = shreg_reg[DIGEST_BITS-1 -: 4];
    assign k_is_hex = (32'(k_reg) < NCHARS_U);

    always_comb begin
        char_k = 8'h0A;
        if (k_is_hex) begin
            if (nibble <= 4'd9) begin
                char_k = 8'h30 + {4'h0, nibble};
            end else begin
                char_k = HEX_A + {4'h0, nibble} - 8'd10;
            end
        end else if (k_reg != K_LAST) begin
            char_k = 8'h0D;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            k_reg       <= '0;
            shreg_reg   <= '0;
            tx_send_reg <= 1'b0;
            tx_data_reg <= 8'h00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            shreg_reg   <= shreg_next;
            tx_send_reg <= tx_send_next;
            tx_data_reg <= tx_data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_ISSUE;
            S_ISSUE: if (!tx_busy) state_next = S_ACK;
            // The transmitter latches the byte at the end of ACK; HOLD gives
            // its busy flag a cycle to rise before DRAIN starts looking at it.
            S_ACK:   state_next = S_HOLD;
            S_HOLD:  state_next = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    state_next = (k_reg == K_LAST) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        k_next       = k_reg;
        shreg_next   = shreg_reg;
        tx_send_next = 1'b0;
        tx_data_next = tx_data_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    shreg_next = digest;
                    k_next     = '0;
                    busy_next  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!tx_busy) begin
                    tx_send_next = 1'b1;
                    tx_data_next = char_k;
                end
            end
            S_DRAIN: begin
                if (!tx_busy && (k_reg != K_LAST)) begin
                    k_next = k_reg + 1'b1;
                    // Past the hex part the shift register is no longer read.
                    if (k_is_hex) begin
                        shreg_next = shreg_reg << 4;
                    end
                end
            end
            S_DONE: begin
                done_next = 1'b1;
                busy_next = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
